// File: rtl/port_kbd.sv
// PS/2 keyboard receiver with byte FIFO, exposed on port I/O at 60h (data) and 64h (status).
// Optional macro PORT_KBD_PARITY_EN enables odd-parity checking of received frames.
module port_kbd #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] port_a,
  input  logic [7:0]  port_d,
  output logic [7:0]  port_q,
  input  logic        pr,
  input  logic        pw,
  input  logic        ps2_clk,
  input  logic        ps2_dat
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] DATA_PORT = 16'h0060;
  localparam logic [15:0] STAT_PORT = 16'h0064;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [1:0]    ck_s, dt_s;
  logic          ck_d;
  logic          fall_c, bit_c;

  rx_state_t     state, state_n;
  logic [7:0]    sh, sh_n;
  logic [2:0]    bcnt, bcnt_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt;
  logic          timeout_c, par_ok_c, push_c, perr_set_c;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [7:0]    last;
  logic          ovr, perr;
  logic          empty_c, full_c, pop_c, wr_c, ovr_set_c, clr_c;
  logic [7:0]    head_c;
  logic          unused_c;

  // Two-flop synchronisers plus one delay flop for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
      ck_d <= 1'b1;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_dat};
      ck_d <= ck_s[1];
    end
  end

  assign fall_c = ck_d & ~ck_s[1];
  assign bit_c  = dt_s[1];

  // Receiver state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= 8'h00;
      bcnt  <= 3'd0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bcnt  <= bcnt_n;
      par   <= par_n;
    end
  end

  // Inactivity counter; saturates so a stalled frame stays abandoned
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == IDLE || fall_c) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout_c = (state != IDLE) && (tcnt == TW'(TIMEOUT));

`ifdef PORT_KBD_PARITY_EN
  assign par_ok_c = ^{sh, par};
  assign unused_c = ^port_d;
`else
  assign par_ok_c = 1'b1;
  assign unused_c = ^{port_d, par};
`endif

  // Receiver next-state: timeout has priority over a coincident edge
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    bcnt_n     = bcnt;
    par_n      = par;
    push_c     = 1'b0;
    perr_set_c = 1'b0;
    if (timeout_c) begin
      state_n = IDLE;
    end else if (fall_c) begin
      case (state)
        IDLE: begin
          if (!bit_c) begin
            state_n = DATA;
            bcnt_n  = 3'd0;
          end
        end
        DATA: begin
          sh_n   = {bit_c, sh[7:1]};
          bcnt_n = bcnt + 3'd1;
          if (bcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = bit_c;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (bit_c && par_ok_c) push_c = 1'b1;
          else                   perr_set_c = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign empty_c   = (count == '0);
  assign full_c    = (count == CW'(DEPTH));
  assign head_c    = mem[rptr];
  assign pop_c     = pr && (port_a == DATA_PORT) && !empty_c;
  assign wr_c      = push_c && (!full_c || pop_c);
  assign ovr_set_c = push_c && full_c && !pop_c;
  assign clr_c     = pw && (port_a == STAT_PORT);

  always_ff @(posedge clock) begin
    if (wr_c) mem[wptr] <= sh;
  end

  // FIFO pointers, last-popped byte and sticky flags (set beats clear)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      last  <= 8'h00;
      ovr   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      if (wr_c) wptr <= wptr + AW'(1);
      if (pop_c) begin
        rptr <= rptr + AW'(1);
        last <= head_c;
      end
      case ({wr_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovr_set_c)  ovr <= 1'b1;
      else if (clr_c) ovr <= 1'b0;
      if (perr_set_c) perr <= 1'b1;
      else if (clr_c) perr <= 1'b0;
    end
  end

  // Read mux, valid in the strobe cycle
  always_comb begin
    port_q = 8'hFF;
    if (port_a == DATA_PORT)      port_q = empty_c ? last : head_c;
    else if (port_a == STAT_PORT) port_q = {5'b0, perr, ovr, ~empty_c};
  end

endmodule

// File: tb/tb_port_kbd.sv
// Scoreboard bench for port_kbd: random PS/2 frames and port accesses against a queue-based model.
module tb_port_kbd;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int          H       = 10;
`ifdef PORT_KBD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] port_a = 16'h0000;
  logic [7:0]  port_d = 8'h00;
  logic [7:0]  port_q;
  logic        pr = 1'b0;
  logic        pw = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;

  port_kbd #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .port_a(port_a), .port_d(port_d), .port_q(port_q),
    .pr(pr), .pw(pw), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
  );

  always #5 clock = ~clock;

  // Reference model: keyboard buffer as a bounded queue plus sticky flags
  logic [7:0]  mq[$];
  logic [7:0]  m_last;
  bit          m_ovr, m_perr;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_a[$];
  int          checks = 0;
  int          passed = 0;

  always @(negedge clock) begin
    #2;
    if (pr && !reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_read: port %h got %02h, no expected value queued", port_a, port_q);
      end else begin
        logic [7:0]  e;
        logic [15:0] a;
        e = exp_q.pop_front();
        a = exp_a.pop_front();
        if (port_q === e && port_a === a) passed++;
        else $display("FAIL read_%h: got %02h expected %02h (port_a %h)", a, port_q, e, port_a);
      end
    end
  end

  task automatic model_rx(input logic [7:0] b, input bit badp, input bit bads);
    if (bads || (PAR_EN && badp)) m_perr = 1'b1;
    else if (mq.size() == DEPTH)  m_ovr = 1'b1;
    else                          mq.push_back(b);
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 8'h00;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    logic [7:0] e;
    if (a == 16'h0060) begin
      if (mq.size() != 0) begin
        e = mq.pop_front();
        m_last = e;
      end else begin
        e = m_last;
      end
    end else if (a == 16'h0064) begin
      e = {5'b0, m_perr, m_ovr, mq.size() != 0};
    end else begin
      e = 8'hFF;
    end
    exp_q.push_back(e);
    exp_a.push_back(a);
    @(negedge clock);
    port_a = a; pr = 1'b1; pw = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a);
    @(negedge clock);
    port_a = a; pw = 1'b1; pr = 1'b0;
    port_d = 8'($urandom);
    if (a == 16'h0064) begin
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clock);
    pr = 1'b0; pw = 1'b0; port_a = 16'h0000;
  endtask

  // mode 0: plain; 1: pop 60h in the push cycle; 2: read 64h three cycles after last edge
  task automatic send_frame(input logic [7:0] b, input bit badp, input bit bads, input int mode);
    logic [10:0] bits;
    int k;
    bits = {~bads, (~(^b)) ^ badp, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      repeat (H) @(negedge clock);
      ps2_clk = 1'b0;
      k = 0;
      if (i == 10 && mode == 1) begin
        @(negedge clock);
        rd(16'h0060);
        model_rx(b, badp, bads);
        idle();
        k = 3;
      end else if (i == 10 && mode == 2) begin
        repeat (2) @(negedge clock);
        model_rx(b, badp, bads);
        rd(16'h0064);
        idle();
        k = 4;
      end
      repeat (H - k) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (H) @(negedge clock);
    if (mode == 0) model_rx(b, badp, bads);
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'($urandom);
      repeat (H) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clock);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pr = 1'b0; pw = 1'b0;
    repeat (3) @(negedge clock);
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [15:0] a;
    do_reset();
    rd(16'h0064); rd(16'h0060); rd(16'h0123); idle();

    // single frame, latency, pop and last-byte hold
    send_frame(8'h1C, 1'b0, 1'b0, 2);
    rd(16'h0060); rd(16'h0064); rd(16'h0060); idle();

    // overrun with nine frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
    rd(16'h0064);
    for (int i = 0; i < 8; i++) rd(16'h0060);
    rd(16'h0064); idle();
    wr(16'h0064); idle();
    rd(16'h0064); idle();

    // wrong parity
    send_frame(8'h55, 1'b1, 1'b0, 0);
    rd(16'h0064); rd(16'h0060); rd(16'h0064); idle();
    wr(16'h0064); idle();

    // bad stop bit
    send_frame(8'h3A, 1'b0, 1'b1, 0);
    rd(16'h0064); rd(16'h0060); idle();
    wr(16'h0060); idle(); rd(16'h0064); idle();
    wr(16'h0064); idle();

    // abandoned partial frame then a good one
    partial(5);
    repeat (TIMEOUT + 10) @(negedge clock);
    send_frame(8'hAA, 1'b0, 1'b0, 0);
    rd(16'h0060); rd(16'h0064); idle();

    // pop coincident with push into a full FIFO
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 0);
    send_frame(8'hE7, 1'b0, 1'b0, 1);
    rd(16'h0064);
    for (int i = 0; i < 8; i++) rd(16'h0060);
    rd(16'h0064); idle();

    // reset mid-frame
    send_frame(8'h42, 1'b0, 1'b0, 0);
    partial(4);
    do_reset();
    rd(16'h0064); rd(16'h0060); idle();
    send_frame(8'h9D, 1'b0, 1'b0, 0);
    rd(16'h0064); rd(16'h0060); rd(16'h0064); idle();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0);
      end else if (r <= 6) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) rd(16'h0060);
        idle();
      end else if (r == 7) begin
        rd(16'h0064); idle();
      end else if (r == 8) begin
        case ($urandom_range(0, 2))
          0:       a = 16'h0064;
          1:       a = 16'h0060;
          default: a = 16'($urandom);
        endcase
        wr(a); idle();
      end else begin
        a = 16'($urandom);
        rd(a); idle();
      end
    end
    rd(16'h0064); idle();
    repeat (4) @(negedge clock);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
